// File: rtl/bus_cs_controller_pkg.sv
// Shared types and constants for the 8088 chip-select / wait-state controller.
package bus_cs_pkg;

  localparam int unsigned NUM_REGIONS = 4;
  localparam int unsigned ADDR_W      = 20;
  localparam int unsigned WAIT_W      = 3;

  typedef logic [NUM_REGIONS-1:0] region_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    DATA,
    END
  } state_t;

endpackage

// File: rtl/bus_cs_controller_if.sv
// Demultiplexed 8088 bus signals seen by the chip-select controller.
interface bus_cs_controller_if;
  import bus_cs_pkg::*;

  logic              ALE;
  logic              IOM;
  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] Address;
  region_vec_t       CS;
  logic              READY;
  logic              DEC_ERR;

  modport master (
    output ALE, IOM, RD, WR, Address,
    input  CS, READY, DEC_ERR
  );

  modport slave (
    input  ALE, IOM, RD, WR, Address,
    output CS, READY, DEC_ERR
  );

endinterface

// File: rtl/bus_cs_controller_region_decoder.sv
// Combinational address/IOM decode into a priority-resolved one-hot region hit.
module region_decoder
  import bus_cs_pkg::*;
#(
  parameter logic [ADDR_W-1:0] REG_BASE [NUM_REGIONS] = '{20'h00000, 20'h80000, 20'h00000, 20'h00100},
  parameter logic [ADDR_W-1:0] REG_MASK [NUM_REGIONS] = '{20'h80000, 20'h80000, 20'hFFF00, 20'hFFF00},
  parameter logic [NUM_REGIONS-1:0] REG_IOM = 4'b1100,
  parameter logic [WAIT_W-1:0] REG_WAIT [NUM_REGIONS] = '{3'd0, 3'd2, 3'd1, 3'd3}
) (
  input  logic [ADDR_W-1:0] Address,
  input  logic              IOM,
  output region_vec_t       hit_vec,
  output logic              hit,
  output logic [WAIT_W-1:0] wait_cnt
);

  // Lowest index wins: once a hit is recorded, higher regions are ignored.
  always_comb begin
    hit_vec  = '0;
    hit      = 1'b0;
    wait_cnt = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!hit &&
          ((Address & REG_MASK[i]) == (REG_BASE[i] & REG_MASK[i])) &&
          (IOM == REG_IOM[i])) begin
        hit_vec[i] = 1'b1;
        hit        = 1'b1;
        wait_cnt   = REG_WAIT[i];
      end
    end
  end

endmodule

// File: rtl/bus_cs_controller.sv
// Chip-select and wait-state controller for the 8088 bus.
// Optional BUS_TIMEOUT_EN: abandon cycles stuck 255 clocks in ADDR or DATA.
module bus_cs_controller
  import bus_cs_pkg::*;
#(
  parameter logic [ADDR_W-1:0] REG_BASE [NUM_REGIONS] = '{20'h00000, 20'h80000, 20'h00000, 20'h00100},
  parameter logic [ADDR_W-1:0] REG_MASK [NUM_REGIONS] = '{20'h80000, 20'h80000, 20'hFFF00, 20'hFFF00},
  parameter logic [NUM_REGIONS-1:0] REG_IOM = 4'b1100,
  parameter logic [WAIT_W-1:0] REG_WAIT [NUM_REGIONS] = '{3'd0, 3'd2, 3'd1, 3'd3}
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bus_cs_controller_if.slave   bus
);

  state_t            state_q, state_d;
  region_vec_t       cs_q, cs_d;
  logic              ready_q, ready_d;
  logic              dec_err_q, dec_err_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  region_vec_t       dec_hit_vec;
  logic              dec_hit;
  logic [WAIT_W-1:0] dec_wait;
  logic              tmo_hit;

  region_decoder #(
    .REG_BASE (REG_BASE),
    .REG_MASK (REG_MASK),
    .REG_IOM  (REG_IOM),
    .REG_WAIT (REG_WAIT)
  ) u_region_decoder (
    .Address  (bus.Address),
    .IOM      (bus.IOM),
    .hit_vec  (dec_hit_vec),
    .hit      (dec_hit),
    .wait_cnt (dec_wait)
  );

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == 8'd254);

  always_ff @(posedge CLK) begin
    if (!RESET) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cs_q      <= '0;
      ready_q   <= 1'b1;
      dec_err_q <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      ready_q   <= ready_d;
      dec_err_q <= dec_err_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  // Per-state behaviour first, then timeout, then ALE last so a new address phase always wins.
  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    ready_d   = ready_q;
    dec_err_d = 1'b0;
    cnt_d     = cnt_q;
    wait_d    = wait_q;

    case (state_q)
      IDLE: begin
        cs_d    = '0;
        ready_d = 1'b1;
      end
      ADDR: begin
        if (!bus.RD || !bus.WR) begin
          if (wait_q == '0) begin
            state_d = DATA;
          end else begin
            cnt_d   = wait_q;
            ready_d = 1'b0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_W'(1)) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      DATA: begin
        ready_d = 1'b1;
        if (bus.RD && bus.WR) state_d = END;
      end
      END: begin
        cs_d    = '0;
        state_d = IDLE;
      end
      default: begin
        cs_d    = '0;
        ready_d = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (tmo_hit && ((state_q == ADDR) || (state_q == DATA))) begin
      state_d   = IDLE;
      cs_d      = '0;
      ready_d   = 1'b1;
      cnt_d     = '0;
      dec_err_d = 1'b1;
    end

    if (bus.ALE) begin
      ready_d = 1'b1;
      cnt_d   = '0;
      if (dec_hit) begin
        cs_d    = dec_hit_vec;
        wait_d  = dec_wait;
        state_d = ADDR;
      end else begin
        cs_d      = '0;
        dec_err_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_comb begin
    tmo_d = '0;
    if ((state_d == state_q) && !bus.ALE &&
        ((state_q == ADDR) || (state_q == DATA))) begin
      tmo_d = tmo_q + 8'd1;
    end
  end
`endif

  assign bus.CS      = ((state_q == IDLE) && bus.ALE) ? dec_hit_vec : cs_q;
  assign bus.READY   = ready_q;
  assign bus.DEC_ERR = dec_err_q;

endmodule

// File: tb/tb_bus_cs_controller.sv
// Directed self-checking bench for bus_cs_controller (BUS_TIMEOUT_EN case guarded).
module tb_bus_cs_controller;
  import bus_cs_pkg::*;

  logic CLK;
  logic RESET;
  int   total;
  int   bad;

  bus_cs_controller_if bus ();

  bus_cs_controller dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full read or write cycle with a bounded count of READY=0 cycles.
  task automatic bus_cycle(input logic [19:0] addr, input logic iom, input logic is_wr,
                           input logic [3:0] exp_cs, input int exp_wait);
    int n;
    bus.Address = addr;
    bus.IOM     = iom;
    bus.ALE     = 1'b1;
    #1;
    chk("cs_ale", 32'(bus.CS), 32'(exp_cs));
    tick();
    bus.ALE = 1'b0;
    chk("cs_addr", 32'(bus.CS), 32'(exp_cs));
    chk("ready_addr", 32'(bus.READY), 32'd1);
    if (is_wr) bus.WR = 1'b0;
    else       bus.RD = 1'b0;
    n = 0;
    tick();
    while (bus.READY === 1'b0 && n < 20) begin
      n++;
      chk("cs_wait", 32'(bus.CS), 32'(exp_cs));
      tick();
    end
    chk("wait_cycles", 32'(n), 32'(exp_wait));
    chk("ready_data", 32'(bus.READY), 32'd1);
    bus.RD = 1'b1;
    bus.WR = 1'b1;
    tick();
    chk("cs_end", 32'(bus.CS), 32'(exp_cs));
    tick();
    chk("cs_after_end", 32'(bus.CS), 32'd0);
    chk("ready_idle", 32'(bus.READY), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RESET = 1'b0;
    bus.ALE     = 1'b0;
    bus.IOM     = 1'b0;
    bus.RD      = 1'b1;
    bus.WR      = 1'b1;
    bus.Address = '0;
    tick();
    tick();
    RESET = 1'b1;
    chk("rst_cs", 32'(bus.CS), 32'd0);
    chk("rst_ready", 32'(bus.READY), 32'd1);
    chk("rst_dec_err", 32'(bus.DEC_ERR), 32'd0);

    // Region 0 memory read, no waits; region 1 write with 2 waits.
    bus_cycle(20'h00123, 1'b0, 1'b0, 4'b0001, 0);
    bus_cycle(20'h8ABCD, 1'b0, 1'b1, 4'b0010, 2);
    // I/O regions 3 and 2.
    bus_cycle(20'h00142, 1'b1, 1'b0, 4'b1000, 3);
    bus_cycle(20'h00042, 1'b1, 1'b1, 4'b0100, 1);

    // Unmapped I/O address.
    bus.Address = 20'h00300;
    bus.IOM     = 1'b1;
    bus.ALE     = 1'b1;
    #1;
    chk("unmapped_cs_ale", 32'(bus.CS), 32'd0);
    tick();
    bus.ALE = 1'b0;
    chk("unmapped_dec_err", 32'(bus.DEC_ERR), 32'd1);
    chk("unmapped_cs", 32'(bus.CS), 32'd0);
    chk("unmapped_ready", 32'(bus.READY), 32'd1);
    chk("unmapped_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk("unmapped_dec_err_clr", 32'(bus.DEC_ERR), 32'd0);

    // Reset during WAIT of a region 3 cycle.
    bus.Address = 20'h00142;
    bus.IOM     = 1'b1;
    bus.ALE     = 1'b1;
    tick();
    bus.ALE = 1'b0;
    bus.RD  = 1'b0;
    tick();
    chk("rstw_ready0", 32'(bus.READY), 32'd0);
    chk("rstw_cs", 32'(bus.CS), 32'b1000);
    tick();
    RESET = 1'b0;
    tick();
    chk("rstw_cs_clr", 32'(bus.CS), 32'd0);
    chk("rstw_ready1", 32'(bus.READY), 32'd1);
    RESET  = 1'b1;
    bus.RD = 1'b1;
    tick();
    bus_cycle(20'h00042, 1'b1, 1'b0, 4'b0100, 1);

    // ALE during WAIT aborts and restarts at ADDR with the new region.
    bus.Address = 20'h8ABCD;
    bus.IOM     = 1'b0;
    bus.ALE     = 1'b1;
    tick();
    bus.ALE = 1'b0;
    bus.WR  = 1'b0;
    tick();
    chk("abort_ready0", 32'(bus.READY), 32'd0);
    bus.WR      = 1'b1;
    bus.Address = 20'h00123;
    bus.ALE     = 1'b1;
    #1;
    chk("abort_cs_held", 32'(bus.CS), 32'b0010);
    tick();
    bus.ALE = 1'b0;
    chk("abort_ready1", 32'(bus.READY), 32'd1);
    chk("abort_cs_new", 32'(bus.CS), 32'b0001);
    chk("abort_state", 32'(dut.state_q), 32'(ADDR));
    bus.RD = 1'b0;
    tick();
    chk("abort_ready_data", 32'(bus.READY), 32'd1);
    bus.RD = 1'b1;
    tick();
    tick();
    chk("abort_cs_idle", 32'(bus.CS), 32'd0);

`ifdef BUS_TIMEOUT_EN
    begin
      int n;
      bus.Address = 20'h00123;
      bus.IOM     = 1'b0;
      bus.ALE     = 1'b1;
      tick();
      bus.ALE = 1'b0;
      n = 0;
      while (bus.CS !== 4'b0000 && n < 300) begin
        tick();
        n++;
      end
      chk("tmo_cycles", 32'(n), 32'd255);
      chk("tmo_dec_err", 32'(bus.DEC_ERR), 32'd1);
      chk("tmo_ready", 32'(bus.READY), 32'd1);
      tick();
      chk("tmo_dec_err_clr", 32'(bus.DEC_ERR), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
